// File: rtl/pll_dyn_ctrl_if.sv
// Divider reconfiguration handshake between a requester and pll_dyn_ctrl.
interface pll_dyn_ctrl_if;
  logic       I_cfg_valid;
  logic       O_cfg_ready;
  logic [5:0] I_idsel;
  logic [5:0] I_fbdsel;
  logic [5:0] I_odsel;

  modport master (output I_cfg_valid, I_idsel, I_fbdsel, I_odsel, input O_cfg_ready);
  modport slave  (input I_cfg_valid, I_idsel, I_fbdsel, I_odsel, output O_cfg_ready);
endinterface

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic reconfiguration / lock qualification controller.
// Optional lock timeout with retry: define PLL_LOCK_TIMEOUT_EN.
module pll_dyn_ctrl #(
  parameter int         RST_HOLD_CYC    = 16,
  parameter int         LOCK_STABLE_CYC = 1024,  // must be >= 2
  parameter int         TIMEOUT_CYC     = 65535,
  parameter logic [5:0] INIT_IDSEL      = 6'd0,
  parameter logic [5:0] INIT_FBDSEL     = 6'd0,
  parameter logic [5:0] INIT_ODSEL      = 6'd0
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  pll_dyn_ctrl_if.slave  cfg,
  output logic [5:0]     O_idsel,
  output logic [5:0]     O_fbdsel,
  output logic [5:0]     O_odsel,
  output logic           O_pll_reset,
  input  logic           I_pll_lock,
  output logic           O_locked,
  output logic           O_user_rst_n,
  output logic           O_timeout
);

  localparam int MAX_AB = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int MAXP   = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W  = $clog2(MAXP) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RST, WAIT_LOCK, STABLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             lock_s;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= I_pll_lock;
      lock_s <= sync1;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] tcnt;
  logic             tmo_hit;

  // Only WAIT_LOCK/STABLE time counts; any other state restarts the budget.
  assign tmo_hit = ((state == WAIT_LOCK) || (state == STABLE)) &&
                   (tcnt >= CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)                                   tcnt <= '0;
    else if ((state != WAIT_LOCK) && (state != STABLE)) tcnt <= '0;
    else if (tmo_hit)                               tcnt <= '0;
    else if (tcnt != CNT_MAX)                       tcnt <= tcnt + 1'b1;
  end
`else
  assign O_timeout = 1'b0;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state           <= RST;
      cnt             <= '0;
      O_pll_reset     <= 1'b1;
      O_locked        <= 1'b0;
      O_user_rst_n    <= 1'b0;
      cfg.O_cfg_ready <= 1'b0;
      O_idsel         <= INIT_IDSEL;
      O_fbdsel        <= INIT_FBDSEL;
      O_odsel         <= INIT_ODSEL;
`ifdef PLL_LOCK_TIMEOUT_EN
      O_timeout       <= 1'b0;
`endif
    end else begin
`ifdef PLL_LOCK_TIMEOUT_EN
      O_timeout <= 1'b0;
`endif
      case (state)
        RST: begin
          if (cnt >= CNT_W'(RST_HOLD_CYC - 1)) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            O_pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
`ifdef PLL_LOCK_TIMEOUT_EN
          if (tmo_hit) begin
            state       <= RST;
            cnt         <= '0;
            O_pll_reset <= 1'b1;
            O_timeout   <= 1'b1;
          end else
`endif
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
`ifdef PLL_LOCK_TIMEOUT_EN
          if (tmo_hit) begin
            state       <= RST;
            cnt         <= '0;
            O_pll_reset <= 1'b1;
            O_timeout   <= 1'b1;
          end else
`endif
          if (!lock_s) begin
            state <= WAIT_LOCK;
          // The lock-high cycle seen in WAIT_LOCK is the first of the run,
          // so STABLE needs LOCK_STABLE_CYC-1 more.
          end else if (cnt >= CNT_W'(LOCK_STABLE_CYC - 2)) begin
            state           <= RUN;
            cnt             <= '0;
            O_locked        <= 1'b1;
            O_user_rst_n    <= 1'b1;
            cfg.O_cfg_ready <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // Lock loss wins over a same-cycle request; the request is dropped.
          if (!lock_s) begin
            state           <= WAIT_LOCK;
            O_locked        <= 1'b0;
            O_user_rst_n    <= 1'b0;
            cfg.O_cfg_ready <= 1'b0;
          end else if (cfg.I_cfg_valid) begin
            state           <= RST;
            cnt             <= '0;
            O_pll_reset     <= 1'b1;
            O_locked        <= 1'b0;
            O_user_rst_n    <= 1'b0;
            cfg.O_cfg_ready <= 1'b0;
            O_idsel         <= cfg.I_idsel;
            O_fbdsel        <= cfg.I_fbdsel;
            O_odsel         <= cfg.I_odsel;
          end
        end
        default: begin
          state       <= RST;
          cnt         <= '0;
          O_pll_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scenario bench for pll_dyn_ctrl; accepted divider sets are scoreboarded.
module tb_pll_dyn_ctrl;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int LSC = 32;
  localparam int TMO = 100;
`else
  localparam int LSC = 1024;
  localparam int TMO = 65535;
`endif
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_lock = 1'b0;
  logic [5:0] idsel, fbdsel, odsel;
  logic pll_reset, locked, user_rst_n, timeout;

  pll_dyn_ctrl_if cfg_if();

  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];
  logic [17:0] cur;

  pll_dyn_ctrl #(
    .RST_HOLD_CYC(HOLD), .LOCK_STABLE_CYC(LSC), .TIMEOUT_CYC(TMO),
    .INIT_IDSEL(6'd0), .INIT_FBDSEL(6'd0), .INIT_ODSEL(6'd0)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .cfg(cfg_if),
    .O_idsel(idsel), .O_fbdsel(fbdsel), .O_odsel(odsel),
    .O_pll_reset(pll_reset), .I_pll_lock(pll_lock),
    .O_locked(locked), .O_user_rst_n(user_rst_n), .O_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_locked(input int maxc, output int n);
    n = 0;
    while (!locked && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic send_req(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    cfg_if.I_cfg_valid = 1'b1;
    cfg_if.I_idsel  = a;
    cfg_if.I_fbdsel = b;
    cfg_if.I_odsel  = c;
  endtask

  task automatic test_reset();
    cfg_if.I_cfg_valid = 1'b0;
    cfg_if.I_idsel = '0; cfg_if.I_fbdsel = '0; cfg_if.I_odsel = '0;
    #2 rst_n = 1'b0;
    #2;
    tests++;
    if ({pll_reset, locked, user_rst_n, cfg_if.O_cfg_ready, timeout} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl got=%b want=10000",
               {pll_reset, locked, user_rst_n, cfg_if.O_cfg_ready, timeout});
    end
    tests++;
    if ({idsel, fbdsel, odsel} !== 18'd0) begin
      fails++;
      $display("FAIL reset_sel got=%h want=0", {idsel, fbdsel, odsel});
    end
    cur = '0;
  endtask

  task automatic test_startup();
    int n;
    logic bad_sel;
    bad_sel = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0;
    while (pll_reset && n < 100) begin
      if (n == 5) pll_lock = 1'b1;
      n++;
      tick();
      if ({idsel, fbdsel, odsel} !== 18'd0) bad_sel = 1'b1;
    end
    tests++;
    if (n !== HOLD) begin
      fails++;
      $display("FAIL startup_rst_hold got=%0d want=%0d", n, HOLD);
    end
    wait_locked(LSC + 50, n);
    tests++;
    if (n !== LSC) begin
      fails++;
      $display("FAIL startup_lock_latency got=%0d want=%0d", n, LSC);
    end
    tests++;
    if ({user_rst_n, cfg_if.O_cfg_ready} !== 2'b11) begin
      fails++;
      $display("FAIL startup_run_outs got=%b want=11", {user_rst_n, cfg_if.O_cfg_ready});
    end
    tests++;
    if (bad_sel !== 1'b0) begin
      fails++;
      $display("FAIL startup_sel_stable got=%b want=0", bad_sel);
    end
  endtask

  task automatic test_glitch();
    int n;
    pll_lock = 1'b0;
    n = 0;
    while (locked && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL lockloss_latency got=%0d want=3", n);
    end
    tests++;
    if ({user_rst_n, cfg_if.O_cfg_ready, pll_reset} !== 3'b000) begin
      fails++;
      $display("FAIL lockloss_outs got=%b want=000", {user_rst_n, cfg_if.O_cfg_ready, pll_reset});
    end
    pll_lock = 1'b1;
    repeat (LSC / 2) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_locked(2 * LSC, n);
    tests++;
    if (n !== LSC + 2) begin
      fails++;
      $display("FAIL glitch_relock got=%0d want=%0d", n, LSC + 2);
    end
  endtask

  task automatic test_cfg();
    int n;
    logic bad;
    logic [17:0] got;
    send_req(6'd3, 6'd54, 6'd2);
    exp_q.push_back({6'd3, 6'd54, 6'd2});
    tick();
    cfg_if.I_cfg_valid = 1'b0;
    cfg_if.I_idsel = 6'd63; cfg_if.I_fbdsel = 6'd63; cfg_if.I_odsel = 6'd63;
    tests++;
    if ({locked, user_rst_n, cfg_if.O_cfg_ready, pll_reset} !== 4'b0001) begin
      fails++;
      $display("FAIL cfg_accept_outs got=%b want=0001",
               {locked, user_rst_n, cfg_if.O_cfg_ready, pll_reset});
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL cfg_sel got=empty_queue want=entry");
    end else begin
      got = exp_q.pop_front();
      if ({idsel, fbdsel, odsel} !== got) begin
        fails++;
        $display("FAIL cfg_sel got=%h want=%h", {idsel, fbdsel, odsel}, got);
      end
      cur = got;
    end
    n = 0;
    bad = 1'b0;
    while (pll_reset && n < 100) begin
      n++;
      tick();
      if ({idsel, fbdsel, odsel} !== cur) bad = 1'b1;
    end
    tests++;
    if (n !== HOLD) begin
      fails++;
      $display("FAIL cfg_rst_hold got=%0d want=%0d", n, HOLD);
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL cfg_sel_stable got=%b want=0", bad);
    end
    wait_locked(LSC + 50, n);
    tests++;
    if (n !== LSC) begin
      fails++;
      $display("FAIL cfg_relock got=%0d want=%0d", n, LSC);
    end
  endtask

  task automatic test_lock_drop_cfg();
    pll_lock = 1'b0;
    tick();
    tick();
    send_req(6'd7, 6'd8, 6'd9);
    tick();
    tests++;
    if ({locked, cfg_if.O_cfg_ready, pll_reset} !== 3'b000) begin
      fails++;
      $display("FAIL drop_cfg_outs got=%b want=000", {locked, cfg_if.O_cfg_ready, pll_reset});
    end
    repeat (3) tick();
    cfg_if.I_cfg_valid = 1'b0;
    tests++;
    if ({idsel, fbdsel, odsel} !== cur) begin
      fails++;
      $display("FAIL drop_cfg_sel got=%h want=%h", {idsel, fbdsel, odsel}, cur);
    end
    tests++;
    if (pll_reset !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL drop_cfg_state got=pll_reset:%b queue:%0d want=0/0", pll_reset, exp_q.size());
    end
  endtask

  task automatic test_timeout();
`ifdef PLL_LOCK_TIMEOUT_EN
    int n;
    n = 0;
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if ({timeout, pll_reset} !== 2'b11) begin
      fails++;
      $display("FAIL timeout_first got=%b want=11", {timeout, pll_reset});
    end
    tick();
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_width got=%b want=0", timeout);
    end
    n = 1;
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if (n !== TMO + HOLD) begin
      fails++;
      $display("FAIL timeout_period got=%0d want=%0d", n, TMO + HOLD);
    end
    tests++;
    if ({idsel, fbdsel, odsel} !== cur) begin
      fails++;
      $display("FAIL timeout_sel got=%h want=%h", {idsel, fbdsel, odsel}, cur);
    end
`else
    logic bad_t, bad_r;
    bad_t = 1'b0;
    bad_r = 1'b0;
    repeat (300) begin
      tick();
      if (timeout !== 1'b0) bad_t = 1'b1;
      if (pll_reset !== 1'b0) bad_r = 1'b1;
    end
    tests++;
    if ({bad_t, bad_r} !== 2'b00) begin
      fails++;
      $display("FAIL no_timeout got=%b want=00", {bad_t, bad_r});
    end
`endif
  endtask

  task automatic test_rst_mid();
    int n;
    logic [17:0] got;
    #2 rst_n = 1'b0;
    pll_lock = 1'b1;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (pll_reset && n < 100) begin
      tick();
      n++;
    end
    wait_locked(LSC + 50, n);
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_relock got=%b want=1", locked);
    end
    send_req(6'd5, 6'd6, 6'd7);
    exp_q.push_back({6'd5, 6'd6, 6'd7});
    tick();
    cfg_if.I_cfg_valid = 1'b0;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL rstmid_sel got=empty_queue want=entry");
    end else begin
      got = exp_q.pop_front();
      if ({idsel, fbdsel, odsel} !== got) begin
        fails++;
        $display("FAIL rstmid_sel got=%h want=%h", {idsel, fbdsel, odsel}, got);
      end
      cur = got;
    end
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    cur = '0;
    tests++;
    if ({idsel, fbdsel, odsel} !== cur) begin
      fails++;
      $display("FAIL rstmid_async_sel got=%h want=%h", {idsel, fbdsel, odsel}, cur);
    end
    tests++;
    if ({pll_reset, locked, user_rst_n, cfg_if.O_cfg_ready, timeout} !== 5'b10000) begin
      fails++;
      $display("FAIL rstmid_async_ctrl got=%b want=10000",
               {pll_reset, locked, user_rst_n, cfg_if.O_cfg_ready, timeout});
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_cfg();
    test_lock_drop_cfg();
    test_timeout();
    test_rst_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
